// File: rtl/pipeline_scoreboard.sv
// Register scoreboard: per-register in-flight write counts (all / long-latency) from issue to writeback.
// Optional stall-cycle statistics counter under `PIPELINE_SCOREBOARD_STATS_EN.
module pipeline_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_IDX_W    = 5,
  parameter int NUM_SRC      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [REG_IDX_W-1:0]           issue_dst,
  input  logic                           issue_long,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*REG_IDX_W-1:0]   src_reg,
  output logic [NUM_SRC-1:0]             src_fwd,
  output logic                           stall,
  input  logic                           wb_valid,
  input  logic [REG_IDX_W-1:0]           wb_dst,
  input  logic                           wb_long,
  input  logic                           kill_valid,
  input  logic [REG_IDX_W-1:0]           kill_dst,
  input  logic                           kill_long,
  output logic [7:0]                     outstanding,
  output logic                           err,
  output logic [31:0]                    stall_cycles
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W+1:0] wide_t;

  cnt_t       cnt_q  [NUM_REGS];
  cnt_t       cnt_d  [NUM_REGS];
  cnt_t       lcnt_q [NUM_REGS];
  cnt_t       lcnt_d [NUM_REGS];
  logic [7:0] out_q, out_d;
  logic       err_q, err_d;

  function automatic logic tracked(input logic [REG_IDX_W-1:0] r);
    return (r != '0) && (int'(r) < NUM_REGS);
  endfunction

  logic issue_acc;

  always_comb begin
    issue_ready = 1'b1;
    if (tracked(issue_dst))
      issue_ready = (cnt_q[issue_dst] != cnt_t'(MAX_INFLIGHT));
  end

  assign issue_acc = issue_valid && issue_ready && tracked(issue_dst);

  logic [REG_IDX_W-1:0] rid;
  logic                 inc, linc;
  logic [1:0]           dec, ldec;
  wide_t                csum, lsum;
  cnt_t                 cnew, lnew;
  logic                 under;
  int                   delta;
  int                   tot;

  // Issue, writeback and kill on one register fold into a single net update.
  always_comb begin
    cnt_d  = cnt_q;
    lcnt_d = lcnt_q;
    rid    = '0;
    inc    = 1'b0;
    linc   = 1'b0;
    dec    = '0;
    ldec   = '0;
    csum   = '0;
    lsum   = '0;
    cnew   = '0;
    lnew   = '0;
    under  = 1'b0;
    delta  = 0;
    for (int r = 1; r < NUM_REGS; r++) begin
      rid  = REG_IDX_W'(r);
      inc  = issue_acc && (issue_dst == rid);
      linc = inc && issue_long;
      dec  = {1'b0, wb_valid && (wb_dst == rid)} + {1'b0, kill_valid && (kill_dst == rid)};
      ldec = {1'b0, wb_valid && wb_long && (wb_dst == rid)}
           + {1'b0, kill_valid && kill_long && (kill_dst == rid)};
      csum = {2'b00, cnt_q[r]}  + {{(CNT_W+1){1'b0}}, inc};
      lsum = {2'b00, lcnt_q[r]} + {{(CNT_W+1){1'b0}}, linc};
      if (csum < {{CNT_W{1'b0}}, dec}) begin
        cnew  = '0;
        under = 1'b1;
      end else begin
        cnew = cnt_t'(csum - {{CNT_W{1'b0}}, dec});
      end
      if (lsum < {{CNT_W{1'b0}}, ldec}) begin
        lnew  = '0;
        under = 1'b1;
      end else begin
        lnew = cnt_t'(lsum - {{CNT_W{1'b0}}, ldec});
      end
      // Keep lcnt <= cnt even if short retirements were mislabelled.
      if (lnew > cnew)
        lnew = cnew;
      cnt_d[r]  = cnew;
      lcnt_d[r] = lnew;
      delta     = delta + int'(cnew) - int'(cnt_q[r]);
    end
  end

  always_comb begin
    tot = int'(out_q) + delta;
    if (tot > 255)
      out_d = 8'd255;
    else if (tot < 0)
      out_d = 8'd0;
    else
      out_d = 8'(tot);
    err_d = err_q || under || (issue_valid && !issue_ready);
  end

  logic [REG_IDX_W-1:0] s;
  cnt_t                 sc, slc;
  logic                 byp;

  // Hazard flags look only at registered counts plus the writeback bypass.
  always_comb begin
    src_fwd = '0;
    stall   = 1'b0;
    s       = '0;
    sc      = '0;
    slc     = '0;
    byp     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = src_reg[i*REG_IDX_W +: REG_IDX_W];
      if (src_valid[i] && tracked(s)) begin
        sc         = cnt_q[s];
        slc        = lcnt_q[s];
        src_fwd[i] = (sc > slc);
        byp        = wb_valid && wb_long && (wb_dst == s) && (slc == cnt_t'(1));
        if ((slc != '0) && !byp)
          stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r]  <= '0;
        lcnt_q[r] <= '0;
      end
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r]  <= cnt_d[r];
        lcnt_q[r] <= lcnt_d[r];
      end
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign outstanding = out_q;
  assign err         = err_q;

`ifdef PIPELINE_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: vector table plus hand-written corner-case sequences.
module tb_pipeline_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, issue_long;
  logic [4:0]  issue_dst;
  logic [1:0]  src_valid, src_fwd;
  logic [9:0]  src_reg;
  logic        stall;
  logic        wb_valid, wb_long, kill_valid, kill_long;
  logic [4:0]  wb_dst, kill_dst;
  logic [7:0]  outstanding;
  logic        err;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dst(issue_dst), .issue_long(issue_long),
    .src_valid(src_valid), .src_reg(src_reg), .src_fwd(src_fwd), .stall(stall),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_long(wb_long),
    .kill_valid(kill_valid), .kill_dst(kill_dst), .kill_long(kill_long),
    .outstanding(outstanding), .err(err), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic       iv;  logic [4:0] id; logic il;
    logic [1:0] sv;  logic [4:0] s0; logic [4:0] s1;
    logic       wv;  logic [4:0] wd; logic wl;
    logic       kv;  logic [4:0] kd; logic kl;
    logic       rdy; logic [1:0] fwd; logic stl; logic [7:0] out; logic er;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  int   exp_sc;

  function automatic vec_t mk(input int iv, id, il, sv, s0, s1, wv, wd, wl, kv, kd, kl,
                              rdy, fwd, stl, out, er);
    vec_t v;
    v.iv = 1'(iv);  v.id = 5'(id);  v.il = 1'(il);
    v.sv = 2'(sv);  v.s0 = 5'(s0);  v.s1 = 5'(s1);
    v.wv = 1'(wv);  v.wd = 5'(wd);  v.wl = 1'(wl);
    v.kv = 1'(kv);  v.kd = 5'(kd);  v.kl = 1'(kl);
    v.rdy = 1'(rdy); v.fwd = 2'(fwd); v.stl = 1'(stl); v.out = 8'(out); v.er = 1'(er);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_dst = v.id; issue_long = v.il;
    src_valid   = v.sv; src_reg   = {v.s1, v.s0};
    wb_valid    = v.wv; wb_dst    = v.wd; wb_long    = v.wl;
    kill_valid  = v.kv; kill_dst  = v.kd; kill_long  = v.kl;
  endtask

  // Called at posedge+1: drive, check combinational flags at negedge, registered state after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(e.rdy));
    chk({tag, ".src_fwd"},     32'(src_fwd),     32'(e.fwd));
    chk({tag, ".stall"},       32'(stall),       32'(e.stl));
    @(posedge clk); #1;
    chk({tag, ".outstanding"}, 32'(outstanding), 32'(e.out));
    chk({tag, ".err"},         32'(err),         32'(e.er));
  endtask

  task automatic do_reset(input vec_t during, input int ncyc);
    drive(during);
    reset = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    //           iv id il  sv s0 s1  wv wd wl  kv kd kl  rdy fwd stl out err
    tbl.push_back(mk(1, 5,1,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // load x5
    tbl.push_back(mk(0, 0,0,  1, 5, 0,  0, 0,0,  0, 0,0,  1, 0,1,1,0));
    tbl.push_back(mk(0, 0,0,  1, 5, 0,  0, 0,0,  0, 0,0,  1, 0,1,1,0));
    tbl.push_back(mk(0, 0,0,  1, 5, 0,  1, 5,1,  0, 0,0,  1, 0,0,0,0)); // wb bypass
    tbl.push_back(mk(0, 0,0,  1, 5, 0,  0, 0,0,  0, 0,0,  1, 0,0,0,0));
    tbl.push_back(mk(1, 7,0,  2, 0, 7,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // same-cycle issue invisible
    tbl.push_back(mk(0, 0,0,  2, 0, 7,  0, 0,0,  0, 0,0,  1, 2,0,1,0));
    tbl.push_back(mk(0, 0,0,  2, 0, 7,  1, 7,0,  0, 0,0,  1, 2,0,0,0));
    tbl.push_back(mk(0, 0,0,  2, 0, 7,  0, 0,0,  0, 0,0,  1, 0,0,0,0));
    tbl.push_back(mk(1, 6,1,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // two loads x6
    tbl.push_back(mk(1, 6,1,  1, 6, 0,  0, 0,0,  0, 0,0,  1, 0,1,2,0));
    tbl.push_back(mk(0, 0,0,  1, 6, 0,  1, 6,1,  0, 0,0,  1, 0,1,1,0)); // lcnt 2: no bypass
    tbl.push_back(mk(0, 0,0,  3, 6, 6,  1, 6,1,  0, 0,0,  1, 0,0,0,0));
    tbl.push_back(mk(1, 8,1,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // load + alu x8
    tbl.push_back(mk(1, 8,0,  1, 8, 0,  0, 0,0,  0, 0,0,  1, 0,1,2,0));
    tbl.push_back(mk(0, 0,0,  1, 8, 0,  0, 0,0,  0, 0,0,  1, 1,1,2,0));
    tbl.push_back(mk(0, 0,0,  1, 8, 0,  1, 8,1,  0, 0,0,  1, 1,0,1,0));
    tbl.push_back(mk(0, 0,0,  1, 8, 0,  0, 0,0,  0, 0,0,  1, 1,0,1,0));
    tbl.push_back(mk(0, 0,0,  1, 8, 0,  0, 0,0,  1, 8,0,  1, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,  1, 8, 0,  0, 0,0,  0, 0,0,  1, 0,0,0,0));
    tbl.push_back(mk(1, 9,0,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // issue+wb x9
    tbl.push_back(mk(1, 9,0,  0, 0, 0,  1, 9,0,  0, 0,0,  1, 0,0,1,0));
    tbl.push_back(mk(0, 0,0,  2, 0, 9,  0, 0,0,  0, 0,0,  1, 2,0,1,0));
    tbl.push_back(mk(0, 0,0,  0, 0, 0,  1, 9,0,  0, 0,0,  1, 0,0,0,0));
    tbl.push_back(mk(1,10,1,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // src_valid gating
    tbl.push_back(mk(0, 0,0,  0,10, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0));
    tbl.push_back(mk(0, 0,0,  1,10, 0,  0, 0,0,  0, 0,0,  1, 0,1,1,0));
    tbl.push_back(mk(0, 0,0,  0, 0, 0,  0, 0,0,  1,10,1,  1, 0,0,0,0));
    tbl.push_back(mk(1,11,0,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,1,0)); // wb and kill, different regs
    tbl.push_back(mk(1,12,1,  0, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,2,0));
    tbl.push_back(mk(0, 0,0,  0, 0, 0,  1,11,0,  1,12,1,  1, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,  3, 0, 0,  0, 0,0,  0, 0,0,  1, 0,0,0,0));

    reset = 1'b1;
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    do_reset(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), 2);
    chk("rst.stall_cycles", stall_cycles, 32'd0);
    apply(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0), "rst");

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturate x3 at MAX_INFLIGHT, then one issue too many.
    for (int k = 1; k <= 4; k++)
      apply(mk(1,3,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,k,0), $sformatf("full%0d", k));
    apply(mk(0,3,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,4,0), "full.ready_low");
    apply(mk(1,3,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,4,1), "full.overissue");
    apply(mk(0,0,0, 1,3,0, 0,0,0, 0,0,0, 1,1,0,4,1), "full.fwd");
    do_reset(mk(1,3,0, 0,0,0, 1,3,0, 0,0,0, 0,0,0,0,0), 2);
    apply(mk(0,3,0, 1,3,0, 0,0,0, 0,0,0, 1,0,0,0,0), "full.after_reset");

    // Kill of a load, then a stray writeback, then reg-0 traffic.
    apply(mk(1,4,1, 0,0,0, 0,0,0, 0,0,0, 1,0,0,1,0), "kill.issue");
    apply(mk(0,0,0, 1,4,0, 0,0,0, 1,4,1, 1,0,1,0,0), "kill.kill");
    apply(mk(0,0,0, 1,4,0, 0,0,0, 0,0,0, 1,0,0,0,0), "kill.clear");
    apply(mk(0,0,0, 0,0,0, 1,4,0, 0,0,0, 1,0,0,0,1), "kill.underflow");
    apply(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0,1), "kill.sticky");
    do_reset(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), 1);
    apply(mk(1,0,1, 1,0,0, 0,0,0, 0,0,0, 1,0,0,0,0), "r0.issue");
    apply(mk(0,0,0, 1,0,0, 1,0,1, 1,0,1, 1,0,0,0,0), "r0.wbkill");

    // Held load hazard for ten cycles, then reset with live counts.
    do_reset(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), 1);
    apply(mk(1,13,1, 0,0,0, 0,0,0, 0,0,0, 1,0,0,1,0), "hold.issue");
    for (int k = 0; k < 10; k++)
      apply(mk(0,0,0, 1,13,0, 0,0,0, 0,0,0, 1,0,1,1,0), $sformatf("hold%0d", k));
`ifdef PIPELINE_SCOREBOARD_STATS_EN
    exp_sc = 10;
`else
    exp_sc = 0;
`endif
    chk("hold.stall_cycles", stall_cycles, 32'(exp_sc));
    do_reset(mk(1,14,1, 1,13,0, 1,13,1, 0,0,0, 0,0,0,0,0), 1);
    chk("midrst.stall_cycles", stall_cycles, 32'd0);
    apply(mk(0,14,0, 1,13,0, 0,0,0, 0,0,0, 1,0,0,0,0), "midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
